mpadd_seq: RTL and testbench



---
 rtl/mpadd_pkg.sv | 16 +
 rtl/cla.sv | 35 +++
 rtl/mpadd_seq.sv | 130 +++++++++++++
 tb/tb_mpadd_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mpadd_pkg.sv
// mpadd_pkg: shared types and helpers for the multi-precision add sequencer.
//   mpadd_state_t : sequencer FSM state encoding {IDLE, BUSY, DONE}
//   MPADD_CNT_W   : slice-counter width for N slices, max(1, clog2(N))
package mpadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mpadd_state_t;

  function automatic int MPADD_CNT_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla.sv
// cla: W-bit adder built from generate/propagate terms.
// Ports:
//   i_a, i_b : W-bit addends
//   i_cin    : carry into bit 0
//   o_sum    : W-bit sum
//   o_cout   : carry out of bit W-1
module cla #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < W; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_sum  = w_p ^ w_c[W-1:0];
  assign o_cout = w_c[W];

endmodule

// File: rtl/mpadd_seq.sv
// mpadd_seq: N*W-bit adder that time-multiplexes one W-bit cla over N cycles,
// least-significant slice first, with the carry chained through a register.
// Optional feature macro: MPADD_SUB_EN (adds i_sub; A - B when i_sub = 1).
// Ports:
//   clk, arst_n          : clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready: operand handshake
//   i_a, i_b, i_cin      : N*W-bit operands and carry-in to slice 0
//   i_sub                : subtract select (MPADD_SUB_EN only)
//   o_out_valid/i_out_ready : result handshake
//   o_y, o_cout          : N*W-bit sum and carry out of slice N-1
//
// state | meaning
// IDLE  | waiting for an operand, o_in_ready = 1
// BUSY  | one slice added per cycle, slice counter 0..N-1
// DONE  | result held on o_y/o_cout, o_out_valid = 1
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N*W-1:0] i_a,
  input  logic [N*W-1:0] i_b,
  input  logic           i_cin,
`ifdef MPADD_SUB_EN
  input  logic           i_sub,
`endif
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [N*W-1:0] o_y,
  output logic           o_cout
);

  localparam int NW = N * W;
  localparam int CW = MPADD_CNT_W(N);

  mpadd_state_t  r_state;
  logic [NW-1:0] r_a;
  logic [NW-1:0] r_b;
  logic [NW-1:0] r_y;
  logic          r_c;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_sum;
  logic          w_cout;
  logic [NW-1:0] w_a_shr;
  logic [NW-1:0] w_b_shr;
  logic [NW-1:0] w_y_next;
  logic [NW-1:0] w_b_load;
  logic          w_c_load;
  logic          w_in_ready;
  logic          w_accept;

  // Subtract is A + ~B + 1, so the stored B is inverted and the carry forced.
`ifdef MPADD_SUB_EN
  assign w_b_load = i_sub ? ~i_b : i_b;
  assign w_c_load = i_sub ? 1'b1 : i_cin;
`else
  assign w_b_load = i_b;
  assign w_c_load = i_cin;
`endif

  // Ready in DONE only when the consumer takes the result this cycle.
  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && i_out_ready);
  assign w_accept   = w_in_ready && i_in_valid;

  cla #(.W(W)) u_cla (
    .i_a   (r_a[W-1:0]),
    .i_b   (r_b[W-1:0]),
    .i_cin (r_c),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // New slice sum enters at the top; after N shifts slice 0 sits at the bottom.
  generate
    if (N == 1) begin : g_one
      assign w_a_shr  = '0;
      assign w_b_shr  = '0;
      assign w_y_next = w_sum;
    end else begin : g_many
      assign w_a_shr  = {{W{1'b0}}, r_a[NW-1:W]};
      assign w_b_shr  = {{W{1'b0}}, r_b[NW-1:W]};
      assign w_y_next = {w_sum, r_y[NW-1:W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= w_b_load;
      r_c     <= w_c_load;
      r_cnt   <= '0;
      r_state <= BUSY;
    end else begin
      case (r_state)
        BUSY: begin
          r_a   <= w_a_shr;
          r_b   <= w_b_shr;
          r_y   <= w_y_next;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) r_state <= DONE;
        end
        DONE: begin
          if (i_out_ready) r_state <= IDLE;
        end
        IDLE: ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = (r_state == DONE);
  assign o_y         = r_y;
  assign o_cout      = r_c;

endmodule

// File: tb/tb_mpadd_seq.sv
// tb_mpadd_seq: directed-vector bench for mpadd_seq with W=8, N=4.
module tb_mpadd_seq;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NW = W * N;

  logic          clk;
  logic          arst_n;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [NW-1:0] i_a;
  logic [NW-1:0] i_b;
  logic          i_cin;
  logic          i_sub;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [NW-1:0] o_y;
  logic          o_cout;

  int n_chk  = 0;
  int n_fail = 0;

  mpadd_seq #(.W(W), .N(N)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cin      (i_cin),
`ifdef MPADD_SUB_EN
    .i_sub      (i_sub),
`endif
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_y        (o_y),
    .o_cout     (o_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand, scramble the inputs afterwards, wait for the result.
  task automatic start_and_wait(input string tag, input logic [NW-1:0] a,
                                input logic [NW-1:0] b, input logic cin,
                                input logic sub, input logic [NW-1:0] ey,
                                input logic ec);
    int lat;
    @(negedge clk);
    i_a = a; i_b = b; i_cin = cin; i_sub = sub; i_in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(o_in_ready), 64'd1);
    @(negedge clk);
    i_in_valid = 1'b0;
    i_a = 32'hDEADBEEF; i_b = 32'h5A5A5A5A; i_cin = ~cin; i_sub = ~sub;
    lat = 1;
    while (!o_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    chk({tag, "_y"}, 64'(o_y), 64'(ey));
    chk({tag, "_cout"}, 64'(o_cout), 64'(ec));
  endtask

  task automatic do_add(input string tag, input logic [NW-1:0] a,
                        input logic [NW-1:0] b, input logic cin,
                        input logic sub, input logic [NW-1:0] ey,
                        input logic ec);
    start_and_wait(tag, a, b, cin, sub, ey, ec);
    i_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_valid"}, 64'(o_out_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(o_in_ready), 64'd1);
    i_out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    arst_n = 1'b0; i_in_valid = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0;
    i_sub = 1'b0; i_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_y", 64'(o_y), 64'd0);
    chk("rst_cout", 64'(o_cout), 64'd0);
    chk("rst_valid", 64'(o_out_valid), 64'd0);
    chk("rst_ready", 64'(o_in_ready), 64'd1);
    arst_n = 1'b1;

    do_add("ff_plus_1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
    do_add("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);
    do_add("mixed", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0);
    do_add("msb_carry", 32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000001, 1'b1);
    do_add("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1);

    // Consumer stalls for 10 cycles: result must hold, no new operand accepted.
    start_and_wait("hold", 32'h00ABCDEF, 32'h00000011, 1'b0, 1'b0, 32'h00ABCE00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_y", 64'(o_y), 64'h00ABCE00);
      chk("hold_cout", 64'(o_cout), 64'd0);
      chk("hold_valid", 64'(o_out_valid), 64'd1);
      chk("hold_ready", 64'(o_in_ready), 64'd0);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("hold_rel_valid", 64'(o_out_valid), 64'd0);
    chk("hold_rel_ready", 64'(o_in_ready), 64'd1);
    i_out_ready = 1'b0;

    // Back-to-back: second operand accepted in the first DONE cycle.
    @(negedge clk);
    i_out_ready = 1'b1; i_in_valid = 1'b1; i_a = 32'd1; i_b = 32'd2; i_cin = 1'b0; i_sub = 1'b0;
    @(negedge clk);
    i_a = 32'd3; i_b = 32'd4;
    lat = 1;
    while (!o_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat1", 64'(lat), 64'd5);
    chk("b2b_y1", 64'(o_y), 64'd3);
    chk("b2b_ready_done", 64'(o_in_ready), 64'd1);
    @(negedge clk);
    i_in_valid = 1'b0;
    chk("b2b_busy_valid", 64'(o_out_valid), 64'd0);
    lat = 1;
    while (!o_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat2", 64'(lat), 64'd5);
    chk("b2b_y2", 64'(o_y), 64'd7);
    @(negedge clk);
    chk("b2b_idle_ready", 64'(o_in_ready), 64'd1);
    i_out_ready = 1'b0;

    // Reset in the second BUSY cycle aborts the add.
    @(negedge clk);
    i_in_valid = 1'b1; i_a = 32'h11111111; i_b = 32'h22222222; i_cin = 1'b0;
    @(negedge clk);
    i_in_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("abort_y", 64'(o_y), 64'd0);
    chk("abort_cout", 64'(o_cout), 64'd0);
    chk("abort_valid", 64'(o_out_valid), 64'd0);
    chk("abort_ready", 64'(o_in_ready), 64'd1);
    @(negedge clk);
    arst_n = 1'b1;
    do_add("post_rst", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0);

`ifdef MPADD_SUB_EN
    do_add("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
    do_add("sub_ok", 32'd7, 32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
